// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: two requester FIFOs (EX, MEM) drained round-robin into one registered write.
// Optional WB_FWD_EN adds forwarding-compare ports (fwd_addr/fwd_hit/fwd_data/fwd_pending).
module wb_port_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          wr_en,
    output logic [AW-1:0] dest_reg,
    output logic [DW-1:0] value_to_write,
    output logic          g0_drop,
`ifdef WB_FWD_EN
    input  logic [AW-1:0] fwd_addr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          fwd_pending,
`endif
    output logic          busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        GRANT_EX  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    // Requester index 0 is EX, 1 is MEM throughout.
    logic [AW-1:0] r_rd   [2][DEPTH];
    logic [DW-1:0] r_data [2][DEPTH];
    logic [PW-1:0] r_wp   [2];
    logic [PW-1:0] r_rp   [2];
    logic [CW-1:0] r_cnt  [2];
    grant_t        r_last_grant;
    logic          r_wr_en;
    logic [AW-1:0] r_dest;
    logic [DW-1:0] r_value;
    logic          r_g0_drop;

    logic [AW-1:0] w_in_rd   [2];
    logic [DW-1:0] w_in_data [2];
    logic [1:0]    w_in_valid;
    logic [1:0]    w_ready;
    logic [1:0]    w_nempty;
    logic [1:0]    w_push;
    logic [1:0]    w_pop;
    logic [AW-1:0] w_pop_rd;
    logic [DW-1:0] w_pop_data;

    assign w_in_rd[0]   = ex_rd;
    assign w_in_rd[1]   = mem_rd;
    assign w_in_data[0] = ex_data;
    assign w_in_data[1] = mem_data;
    assign w_in_valid   = {mem_valid, ex_valid};

    always_comb begin
        w_ready    = '0;
        w_nempty   = '0;
        w_push     = '0;
        w_pop      = '0;
        w_pop_rd   = '0;
        w_pop_data = '0;
        for (int i = 0; i < 2; i++) begin
            w_ready[i]  = (r_cnt[i] != FULL_CNT);
            w_nempty[i] = (r_cnt[i] != '0);
            w_push[i]   = w_in_valid[i] && w_ready[i] && !flush;
        end
        // On a tie the requester not granted last time wins.
        w_pop[0] = w_nempty[0] && (!w_nempty[1] || (r_last_grant == GRANT_MEM));
        w_pop[1] = w_nempty[1] && !w_pop[0];
        if (w_pop[0]) begin
            w_pop_rd   = r_rd[0][r_rp[0]];
            w_pop_data = r_data[0][r_rp[0]];
        end else begin
            w_pop_rd   = r_rd[1][r_rp[1]];
            w_pop_data = r_data[1][r_rp[1]];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_rd[i][r_wp[i]]   <= w_in_rd[i];
                r_data[i][r_wp[i]] <= w_in_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_last_grant <= GRANT_MEM;
            r_wr_en      <= 1'b0;
            r_dest       <= '0;
            r_value      <= '0;
            r_g0_drop    <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
            r_last_grant <= GRANT_MEM;
            r_wr_en      <= 1'b0;
            r_g0_drop    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) r_wp[i] <= r_wp[i] + PW'(1);
                if (w_pop[i])  r_rp[i] <= r_rp[i] + PW'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CW'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CW'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            if (|w_pop) begin
                r_last_grant <= w_pop[0] ? GRANT_EX : GRANT_MEM;
                // Writes to R0 are discarded; dest/value keep the last real write.
                if (w_pop_rd != '0) begin
                    r_wr_en   <= 1'b1;
                    r_dest    <= w_pop_rd;
                    r_value   <= w_pop_data;
                    r_g0_drop <= 1'b0;
                end else begin
                    r_wr_en   <= 1'b0;
                    r_g0_drop <= 1'b1;
                end
            end else begin
                r_wr_en   <= 1'b0;
                r_g0_drop <= 1'b0;
            end
        end
    end

    assign ex_ready       = w_ready[0];
    assign mem_ready      = w_ready[1];
    assign wr_en          = r_wr_en;
    assign dest_reg       = r_dest;
    assign value_to_write = r_value;
    assign g0_drop        = r_g0_drop;
    assign busy           = w_nempty[0] | w_nempty[1] | r_wr_en;

`ifdef WB_FWD_EN
    logic [PW-1:0] w_fwd_idx;
    logic          w_fwd_match;

    assign fwd_hit  = r_wr_en && (r_dest == fwd_addr) && (fwd_addr != '0);
    assign fwd_data = fwd_hit ? r_value : '0;

    // Scan only occupied slots, starting at each read pointer.
    always_comb begin
        w_fwd_idx   = '0;
        w_fwd_match = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_fwd_idx = r_rp[i] + PW'(k);
                if ((CW'(k) < r_cnt[i]) && (r_rd[i][w_fwd_idx] == fwd_addr)) begin
                    w_fwd_match = 1'b1;
                end
            end
        end
    end

    assign fwd_pending = w_fwd_match && (fwd_addr != '0);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand sequences for reset, async reset and forwarding.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int DW    = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          ex_valid;
    logic          ex_ready;
    logic [AW-1:0] ex_rd;
    logic [DW-1:0] ex_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          wr_en;
    logic [AW-1:0] dest_reg;
    logic [DW-1:0] value_to_write;
    logic          g0_drop;
    logic          busy;
`ifdef WB_FWD_EN
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          fwd_pending;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_rd          (ex_rd),
        .ex_data        (ex_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .wr_en          (wr_en),
        .dest_reg       (dest_reg),
        .value_to_write (value_to_write),
        .g0_drop        (g0_drop),
`ifdef WB_FWD_EN
        .fwd_addr       (fwd_addr),
        .fwd_hit        (fwd_hit),
        .fwd_data       (fwd_data),
        .fwd_pending    (fwd_pending),
`endif
        .busy           (busy)
    );

    typedef struct {
        logic          fl;
        logic          ev;
        logic [AW-1:0] erd;
        logic [DW-1:0] ed;
        logic          mv;
        logic [AW-1:0] mrd;
        logic [DW-1:0] md;
        logic          wr;
        logic [AW-1:0] dest;
        logic [DW-1:0] val;
        logic          g0;
        logic          bsy;
        logic          er;
        logic          mr;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic fl, input logic ev, input int erd, input int ed,
                                input logic mv, input int mrd, input int md,
                                input logic wr, input int dest, input int val,
                                input logic g0, input logic bsy, input logic er, input logic mr);
        vec_t v;
        v.fl = fl; v.ev = ev; v.erd = AW'(erd); v.ed = DW'(ed);
        v.mv = mv; v.mrd = AW'(mrd); v.md = DW'(md);
        v.wr = wr; v.dest = AW'(dest); v.val = DW'(val);
        v.g0 = g0; v.bsy = bsy; v.er = er; v.mr = mr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic ev, input int erd, input int ed,
                         input logic mv, input int mrd, input int md);
        flush     = fl;
        ex_valid  = ev;
        ex_rd     = AW'(erd);
        ex_data   = DW'(ed);
        mem_valid = mv;
        mem_rd    = AW'(mrd);
        mem_data  = DW'(md);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // single EX write, then flush discarding a same-edge push
        vecs.push_back(mk(0,1,3,100, 0,0,0,     0,0,0,      0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     1,3,100,    0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,3,100,    0,0,1,1));
        vecs.push_back(mk(1,1,7,50,  0,0,0,     0,3,100,    0,0,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,3,100,    0,0,1,1));
        // both producers streaming; producers hold offers while not ready
        vecs.push_back(mk(0,1,1,200, 1,8,900,   0,3,100,    0,1,1,1));
        vecs.push_back(mk(0,1,2,300, 1,9,1000,  1,1,200,    0,1,1,0));
        vecs.push_back(mk(0,1,3,400, 1,10,1100, 1,8,900,    0,1,0,1));
        vecs.push_back(mk(0,1,4,500, 1,10,1100, 1,2,300,    0,1,1,0));
        vecs.push_back(mk(0,1,4,500, 1,11,1200, 1,9,1000,   0,1,0,1));
        vecs.push_back(mk(0,0,0,0,   1,11,1200, 1,3,400,    0,1,1,0));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     1,10,1100,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     1,4,500,    0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     1,11,1200,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,11,1200,  0,0,1,1));
        // MEM-only back-to-back, pointers wrap
        vecs.push_back(mk(0,0,0,0,   1,12,1400, 0,11,1200,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   1,13,1500, 1,12,1400,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   1,14,1600, 1,13,1500,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     1,14,1600,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,14,1600,  0,0,1,1));
        // R0 target discarded
        vecs.push_back(mk(0,0,0,0,   1,0,777,   0,14,1600,  0,1,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,14,1600,  1,0,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,14,1600,  0,0,1,1));
        // queued entries on both sides, then flush
        vecs.push_back(mk(0,1,20,10, 1,21,11,   0,14,1600,  0,1,1,1));
        vecs.push_back(mk(0,1,22,12, 1,23,13,   1,20,10,    0,1,1,0));
        vecs.push_back(mk(1,1,24,14, 1,23,13,   0,20,10,    0,0,1,1));
        vecs.push_back(mk(0,0,0,0,   0,0,0,     0,20,10,    0,0,1,1));

        reset = 1'b0;
        drive(0, 1, 3, 55, 0, 0, 0);
`ifdef WB_FWD_EN
        fwd_addr = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst wr_en", 32'(wr_en), 0);
        chk("rst dest", 32'(dest_reg), 0);
        chk("rst value", value_to_write, 0);
        chk("rst g0", 32'(g0_drop), 0);
        chk("rst busy", 32'(busy), 0);
        reset = 1'b1;
        #1;
        chk("rel ex_ready", 32'(ex_ready), 1);
        chk("rel mem_ready", 32'(mem_ready), 1);
        ex_valid = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].fl, vecs[i].ev, int'(vecs[i].erd), int'(vecs[i].ed),
                  vecs[i].mv, int'(vecs[i].mrd), int'(vecs[i].md));
            step();
            chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
            chk($sformatf("v%0d dest", i), 32'(dest_reg), 32'(vecs[i].dest));
            chk($sformatf("v%0d value", i), value_to_write, vecs[i].val);
            chk($sformatf("v%0d g0", i), 32'(g0_drop), 32'(vecs[i].g0));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
            chk($sformatf("v%0d ex_ready", i), 32'(ex_ready), 32'(vecs[i].er));
            chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(vecs[i].mr));
        end

        // async reset while a write is in flight and MEM still holds an entry
        drive(0, 1, 25, 1, 1, 26, 2);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("mid wr_en", 32'(wr_en), 1);
        chk("mid dest", 32'(dest_reg), 25);
        #2;
        reset = 1'b0;
        #1;
        chk("async wr_en", 32'(wr_en), 0);
        chk("async dest", 32'(dest_reg), 0);
        chk("async value", value_to_write, 0);
        chk("async busy", 32'(busy), 0);
        chk("async ex_ready", 32'(ex_ready), 1);
        chk("async mem_ready", 32'(mem_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post rst wr_en", 32'(wr_en), 0);
        chk("post rst busy", 32'(busy), 0);

`ifdef WB_FWD_EN
        drive(0, 1, 5, 1300, 0, 0, 0);
        step();
        drive(0, 1, 6, 7, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        fwd_addr = 5'd5;
        #1;
        chk("fwd5 hit", 32'(fwd_hit), 1);
        chk("fwd5 data", fwd_data, 1300);
        chk("fwd5 pending", 32'(fwd_pending), 0);
        fwd_addr = 5'd6;
        #1;
        chk("fwd6 hit", 32'(fwd_hit), 0);
        chk("fwd6 data", fwd_data, 0);
        chk("fwd6 pending", 32'(fwd_pending), 1);
        fwd_addr = 5'd0;
        #1;
        chk("fwd0 hit", 32'(fwd_hit), 0);
        chk("fwd0 data", fwd_data, 0);
        chk("fwd0 pending", 32'(fwd_pending), 0);
        repeat (3) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
